// File: rtl/rsa_pkg.sv
// rsa_pkg: shared state encoding for the modexp sequencer
package rsa_pkg;
  typedef enum logic [2:0] {
    IDLE, LOAD, CHECK, MUL_GO, MUL_WAIT, SQR_GO, SQR_WAIT, FINISH
  } modexp_state_t;
endpackage

// File: rtl/modmult.sv
// modmult: go latches a,b,n (a,b < n); result = a*b mod n, valid while done pulses, one add/double step per bit of b
module modmult #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             go,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [WIDTH-1:0] n,
  output logic [WIDTH-1:0] result,
  output logic             done
);
  logic             run;
  logic [WIDTH-1:0] a_r, b_r, n_r, acc_r;
  logic [WIDTH:0]   sum, dbl, nn;
  assign nn     = {1'b0, n_r};
  assign sum    = {1'b0, acc_r} + (b_r[0] ? {1'b0, a_r} : '0);
  assign dbl    = {a_r, 1'b0};
  assign result = acc_r;
  always_ff @(posedge clk) begin
    if (rst) begin
      run   <= 1'b0;
      done  <= 1'b0;
      a_r   <= '0;
      b_r   <= '0;
      n_r   <= '0;
      acc_r <= '0;
    end else begin
      done <= 1'b0;
      if (!run) begin
        if (go) begin
          a_r   <= a;
          b_r   <= b;
          n_r   <= n;
          acc_r <= '0;
          run   <= 1'b1;
        end
      end else if (b_r == '0) begin
        run  <= 1'b0;
        done <= 1'b1;
      end else begin
        acc_r <= sum >= nn ? WIDTH'(sum - nn) : WIDTH'(sum);
        a_r   <= dbl >= nn ? WIDTH'(dbl - nn) : WIDTH'(dbl);
        b_r   <= b_r >> 1;
      end
    end
  end
endmodule

// File: rtl/modexp.sv
// modexp: result = base^exponent mod modulus via modmult; start in, busy/done/err/result out, async active-low rst_n
module modexp
  import rsa_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] base,
  input  logic [WIDTH-1:0] exponent,
  input  logic [WIDTH-1:0] modulus,
  output logic [WIDTH-1:0] result,
  output logic             busy,
  output logic             done,
  output logic             err
);
  modexp_state_t    state;
  logic [WIDTH-1:0] base_r, exp_r, mod_r, acc_r, mm_a, mm_result;
  logic             mm_go, mm_done;
  assign mm_go = state == MUL_GO || state == SQR_GO;
  assign mm_a  = state == MUL_GO ? acc_r : base_r;
  modmult #(.WIDTH(WIDTH)) u_modmult (
    .clk    (clk),
    .rst    (~rst_n),
    .go     (mm_go),
    .a      (mm_a),
    .b      (base_r),
    .n      (mod_r),
    .result (mm_result),
    .done   (mm_done)
  );
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state  <= IDLE;
      result <= '0;
      busy   <= 1'b0;
      done   <= 1'b0;
      err    <= 1'b0;
      base_r <= '0;
      exp_r  <= '0;
      mod_r  <= '0;
      acc_r  <= '0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          busy <= start;
          if (start) begin
            base_r <= base;
            exp_r  <= exponent;
            mod_r  <= modulus;
            err    <= 1'b0;
            state  <= LOAD;
          end
        end
        LOAD: begin
          if (mod_r <= WIDTH'(1)) begin
            acc_r <= '0;
            state <= FINISH;
          end else begin
            acc_r  <= WIDTH'(1);
            base_r <= base_r % mod_r;
            state  <= CHECK;
          end
        end
        CHECK: state <= exp_r == '0 ? FINISH : exp_r[0] ? MUL_GO : SQR_GO;
        MUL_GO: state <= MUL_WAIT;
        MUL_WAIT: begin
          if (mm_done) begin
            acc_r <= mm_result;
            if (exp_r[WIDTH-1:1] == '0) begin
              exp_r <= '0;
              state <= CHECK;
            end else begin
              state <= SQR_GO;
            end
          end
        end
        SQR_GO: state <= SQR_WAIT;
        SQR_WAIT: begin
          if (mm_done) begin
            base_r <= mm_result;
            exp_r  <= exp_r >> 1;
            state  <= CHECK;
          end
        end
        FINISH: begin
          result <= acc_r;
          err    <= mod_r == '0;
          done   <= 1'b1;
          state  <= IDLE;
        end
        default: state <= modexp_state_t'('x);
      endcase
    end
  end
endmodule
